// File: rtl/jzjpcc_mmio_bank.sv
// jzjpcc_mmio_bank: memory-mapped I/O bank occupying the top words of the
// 32-bit address space. It provides NUM_PORTS bidirectional 32-bit ports, each
// with a per-bit direction register, an input synchroniser, byte-masked writes
// and, optionally, input-change interrupt latching.
//
// Word map (T = 2^30 as a word index):
//   data port i        : T - NUM_PORTS + i
//   direction reg i    : T - 2*NUM_PORTS + i
//   pending register   : T - 2*NUM_PORTS - 1
//
// Ports:
//   clock, reset      sole clock; synchronous active-high reset
//   memAddress        word address [31:2] from execute
//   memWriteEnable    write strobe for memAddress
//   memByteMask       byte lanes to write
//   memDataToWrite    write data
//   memSelected       combinational region hit for memAddress
//   memDataRead       registered read data for the previous cycle's address
//   portInputs        asynchronous input pins, one 32-bit word per port
//   portOutputs       output registers
//   portDirections    direction registers (1 = output driven)
//   edgeIrq           OR of pending bits (only with JZJPCC_MMIO_EDGE_EN)
//
// Build option: define JZJPCC_MMIO_EDGE_EN to build the pending register,
// previous-value flops and the edgeIrq port. Without it the pending word is
// still decoded but reads 0 and ignores writes.
module jzjpcc_mmio_bank #(
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [29:0]                 memAddress,
  input  logic                        memWriteEnable,
  input  logic [3:0]                  memByteMask,
  input  logic [31:0]                 memDataToWrite,
  output logic                        memSelected,
  output logic [31:0]                 memDataRead,
  input  logic [NUM_PORTS-1:0][31:0]  portInputs,
  output logic [NUM_PORTS-1:0][31:0]  portOutputs,
  output logic [NUM_PORTS-1:0][31:0]  portDirections
`ifdef JZJPCC_MMIO_EDGE_EN
  ,
  output logic                        edgeIrq
`endif
);

  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [30:0] ADDR_TOP  = 31'h4000_0000;
  localparam logic [29:0] DATA_BASE = 30'(ADDR_TOP - 31'(NUM_PORTS));
  localparam logic [29:0] DIR_BASE  = 30'(ADDR_TOP - 31'(2 * NUM_PORTS));
  localparam logic [29:0] PEND_ADDR = DIR_BASE - 30'd1;

  logic             isData;
  logic             isDir;
  logic             isPend;
  logic [IDX_W-1:0] portIdx;
  logic [31:0]      bitMask;
  logic [31:0]      pendWord;
  logic [31:0]      readMux;

  logic [NUM_PORTS-1:0][31:0] syncFf [SYNC_STAGES];
  logic [NUM_PORTS-1:0][31:0] syncedIn;

  // The bank sits at the very top of the space, so each region is a lower bound
  assign memSelected = (memAddress >= PEND_ADDR);
  assign syncedIn    = syncFf[SYNC_STAGES-1];

  // Address decode and byte-lane expansion
  always_comb begin
    isData  = (memAddress >= DATA_BASE);
    isDir   = (memAddress >= DIR_BASE) && !isData;
    isPend  = (memAddress == PEND_ADDR);
    portIdx = isData ? IDX_W'(memAddress - DATA_BASE)
                     : IDX_W'(memAddress - DIR_BASE);
    for (int b = 0; b < 4; b++) begin
      bitMask[8*b +: 8] = {8{memByteMask[b]}};
    end
  end

`ifdef JZJPCC_MMIO_EDGE_EN
  logic [NUM_PORTS-1:0][31:0] prevSync;
  logic [NUM_PORTS-1:0]       pending;
  logic [NUM_PORTS-1:0]       pendSet;
  logic [NUM_PORTS-1:0]       pendClr;

  // Change detection on input-direction bits; W1C from the bus
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      pendSet[i] = |((syncedIn[i] ^ prevSync[i]) & ~portDirections[i]);
    end
    pendClr = (memWriteEnable && isPend) ? NUM_PORTS'(memDataToWrite & bitMask)
                                         : '0;
    pendWord = 32'(pending);
  end

  assign edgeIrq = |pending;

  // Set is applied after clear so a simultaneous edge is never lost
  always_ff @(posedge clock) begin
    if (reset) begin
      prevSync <= '0;
      pending  <= '0;
    end else begin
      prevSync <= syncedIn;
      pending  <= (pending & ~pendClr) | pendSet;
    end
  end
`else
  assign pendWord = '0;
`endif

  // Read mux; data port bits come from the output register or the pin per direction
  always_comb begin
    readMux = '0;
    if (isData) begin
      readMux = (portOutputs[portIdx] & portDirections[portIdx]) |
                (syncedIn[portIdx] & ~portDirections[portIdx]);
    end else if (isDir) begin
      readMux = portDirections[portIdx];
    end else if (isPend) begin
      readMux = pendWord;
    end
  end

  // Registered read, synchroniser chain and byte-masked register writes
  always_ff @(posedge clock) begin
    if (reset) begin
      memDataRead    <= '0;
      portOutputs    <= '0;
      portDirections <= '0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        syncFf[s] <= '0;
      end
    end else begin
      memDataRead <= readMux;
      syncFf[0]   <= portInputs;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        syncFf[s] <= syncFf[s-1];
      end
      if (memWriteEnable && isData) begin
        portOutputs[portIdx] <= (portOutputs[portIdx] & ~bitMask) |
                                (memDataToWrite & bitMask);
      end
      if (memWriteEnable && isDir) begin
        portDirections[portIdx] <= (portDirections[portIdx] & ~bitMask) |
                                   (memDataToWrite & bitMask);
      end
    end
  end

endmodule

// File: tb/tb_jzjpcc_mmio_bank.sv
// Testbench for jzjpcc_mmio_bank: directed scenarios plus randomized traffic
// checked against a word-level reference model of the bank.
module tb_jzjpcc_mmio_bank;

  localparam int NP = 8;
  localparam int SS = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [29:0]          memAddress;
  logic                 memWriteEnable;
  logic [3:0]           memByteMask;
  logic [31:0]          memDataToWrite;
  logic                 memSelected;
  logic [31:0]          memDataRead;
  logic [NP-1:0][31:0]  pins;
  logic [NP-1:0][31:0]  portOutputs;
  logic [NP-1:0][31:0]  portDirections;
`ifdef JZJPCC_MMIO_EDGE_EN
  logic                 edgeIrq;
`endif

  always #5 clock = ~clock;

  jzjpcc_mmio_bank #(.NUM_PORTS(NP), .SYNC_STAGES(SS)) dut (
    .clock(clock),
    .reset(reset),
    .memAddress(memAddress),
    .memWriteEnable(memWriteEnable),
    .memByteMask(memByteMask),
    .memDataToWrite(memDataToWrite),
    .memSelected(memSelected),
    .memDataRead(memDataRead),
    .portInputs(pins),
    .portOutputs(portOutputs),
    .portDirections(portDirections)
`ifdef JZJPCC_MMIO_EDGE_EN
    ,
    .edgeIrq(edgeIrq)
`endif
  );

  // Reference model state
  logic [NP-1:0][31:0] mOut;
  logic [NP-1:0][31:0] mDir;
  logic [31:0]         mPend;
  logic [NP-1:0][31:0] pinHist[$];   // pin values sampled at each edge, newest first
  logic [31:0]         expRead;
  int                  passed = 0;
  int                  total  = 0;

  function automatic logic [29:0] dataAddr(int i);
    return 30'(32'h4000_0000 - NP + i);
  endfunction

  function automatic logic [29:0] dirAddr(int i);
    return 30'(32'h4000_0000 - 2 * NP + i);
  endfunction

  function automatic logic [29:0] pendAddr();
    return 30'(32'h4000_0000 - 2 * NP - 1);
  endfunction

  // Synchronised pin value seen by the bank is the one sampled SS edges ago
  function automatic logic [31:0] modelRead(logic [29:0] a);
    logic [NP-1:0][31:0] syn;
    syn = pinHist[SS-1];
    for (int i = 0; i < NP; i++) begin
      if (a == dataAddr(i)) return (mOut[i] & mDir[i]) | (syn[i] & ~mDir[i]);
      if (a == dirAddr(i)) return mDir[i];
    end
`ifdef JZJPCC_MMIO_EDGE_EN
    if (a == pendAddr()) return mPend;
`endif
    return 32'h0;
  endfunction

  task automatic resetModel();
    mOut    = '0;
    mDir    = '0;
    mPend   = '0;
    expRead = '0;
    pinHist = {};
    for (int s = 0; s <= SS; s++) pinHist.push_front('0);
  endtask

  // One bus cycle: drive, clock, advance model, settle 1 time unit past the edge
  task automatic tick(input logic [29:0] a, input logic we, input logic [3:0] m,
                      input logic [31:0] d);
    logic [31:0] nextRead;
    logic [31:0] bm;
    logic [31:0] lowMask;
    logic [31:0] setBits;
    logic [31:0] clrBits;
    memAddress     = a;
    memWriteEnable = we;
    memByteMask    = m;
    memDataToWrite = d;
    nextRead = modelRead(a);
    @(posedge clock);
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{m[b]}};
    lowMask = (NP >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NP) - 32'd1);
    setBits = '0;
    for (int i = 0; i < NP; i++) begin
      if (((pinHist[SS-1][i] ^ pinHist[SS][i]) & ~mDir[i]) != 32'h0) setBits[i] = 1'b1;
    end
    clrBits = (we && a == pendAddr()) ? (d & bm & lowMask) : 32'h0;
    mPend = (mPend & ~clrBits) | setBits;
    for (int i = 0; i < NP; i++) begin
      if (we && a == dataAddr(i)) mOut[i] = (mOut[i] & ~bm) | (d & bm);
      if (we && a == dirAddr(i))  mDir[i] = (mDir[i] & ~bm) | (d & bm);
    end
    pinHist.push_front(pins);
    void'(pinHist.pop_back());
    expRead = nextRead;
    #1;
  endtask

  task automatic doReset(input logic [29:0] a, input logic we, input logic [3:0] m,
                         input logic [31:0] d);
    reset          = 1'b1;
    memAddress     = a;
    memWriteEnable = we;
    memByteMask    = m;
    memDataToWrite = d;
    @(posedge clock);
    resetModel();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] a;
    doReset(30'h0, 1'b0, 4'h0, 32'h0);
    total++;
    if (memDataRead !== 32'h0) $display("FAIL reset_rd got=%h exp=0", memDataRead);
    else passed++;
    total++;
    if (portOutputs !== '0) $display("FAIL reset_out got=%h exp=0", portOutputs);
    else passed++;
    total++;
    if (portDirections !== '0) $display("FAIL reset_dir got=%h exp=0", portDirections);
    else passed++;
    for (int w = 0; w <= 2 * NP; w++) begin
      a = 30'(32'h4000_0000 - 2 * NP - 1 + w);
      tick(a, 1'b0, 4'h0, 32'h0);
      total++;
      if (memSelected !== 1'b1) $display("FAIL reset_sel addr=%h got=%b exp=1", a, memSelected);
      else passed++;
      total++;
      if (memDataRead !== 32'h0) $display("FAIL reset_map_rd addr=%h got=%h exp=0", a, memDataRead);
      else passed++;
    end
    for (int k = 0; k < 4; k++) begin
      case (k)
        0:       a = pendAddr() - 30'd1;
        1:       a = 30'h0;
        2:       a = 30'h2000_0000;
        default: a = 30'($urandom % 32'(pendAddr()));
      endcase
      tick(a, 1'b1, 4'hF, 32'hFFFF_FFFF);
      total++;
      if (memSelected !== 1'b0) $display("FAIL unsel_sel addr=%h got=%b exp=0", a, memSelected);
      else passed++;
      total++;
      if (memDataRead !== 32'h0) $display("FAIL unsel_rd addr=%h got=%h exp=0", a, memDataRead);
      else passed++;
    end
    total++;
    if (portOutputs !== '0 || portDirections !== '0)
      $display("FAIL unsel_write got_out=%h got_dir=%h exp=0", portOutputs, portDirections);
    else passed++;
  endtask

  task automatic test_byte_mask();
    tick(dataAddr(0), 1'b1, 4'b0101, 32'hDEAD_BEEF);
    tick(dirAddr(0), 1'b1, 4'hF, 32'hFFFF_FFFF);
    tick(dataAddr(0), 1'b0, 4'h0, 32'h0);
    total++;
    if (memDataRead !== 32'h00AD_00EF) $display("FAIL mask_rd got=%h exp=00ad00ef", memDataRead);
    else passed++;
    total++;
    if (portOutputs[0] !== 32'h00AD_00EF) $display("FAIL mask_out got=%h exp=00ad00ef", portOutputs[0]);
    else passed++;
  endtask

  task automatic test_input_latency();
    logic [31:0] exp;
    tick(dirAddr(0), 1'b1, 4'hF, 32'h0000_FFFF);
    tick(dataAddr(0), 1'b1, 4'hF, 32'h1234_5678);
    pins[0] = 32'hAAAA_0000;
    for (int c = 1; c <= SS + 2; c++) begin
      tick(dataAddr(0), 1'b0, 4'h0, 32'h0);
      exp = (c >= SS + 1) ? 32'hAAAA_5678 : 32'h0000_5678;
      total++;
      if (memDataRead !== exp) $display("FAIL latency cyc=%0d got=%h exp=%h", c, memDataRead, exp);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [29:0] a;
    int          k;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, NP-1)] = $urandom;
      else if ($urandom_range(0, 3) == 0) pins[$urandom_range(0, NP-1)][$urandom_range(0, 31)] ^= 1'b1;
      k = $urandom_range(0, 2 * NP + 3);
      if (k < NP)           a = dataAddr(k);
      else if (k < 2 * NP)  a = dirAddr(k - NP);
      else if (k == 2 * NP) a = pendAddr();
      else                  a = 30'($urandom);
      tick(a, 1'($urandom), 4'($urandom), $urandom);
      total++;
      if (memDataRead !== expRead) $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, a, memDataRead, expRead);
      else passed++;
`ifdef JZJPCC_MMIO_EDGE_EN
      total++;
      if (edgeIrq !== (|mPend)) $display("FAIL rand_irq n=%0d got=%b exp=%b", n, edgeIrq, |mPend);
      else passed++;
`endif
      if (n % 16 == 15) begin
        total++;
        if (portOutputs !== mOut || portDirections !== mDir)
          $display("FAIL rand_regs n=%0d got_out=%h exp_out=%h", n, portOutputs, mOut);
        else passed++;
      end
    end
  endtask

`ifdef JZJPCC_MMIO_EDGE_EN
  task automatic test_edge();
    tick(dirAddr(2), 1'b1, 4'hF, 32'h0);
    for (int c = 0; c < SS + 2; c++) tick(30'h0, 1'b0, 4'h0, 32'h0);
    tick(pendAddr(), 1'b1, 4'hF, 32'hFFFF_FFFF);
    total++;
    if (edgeIrq !== 1'b0) $display("FAIL edge_idle got=%b exp=0", edgeIrq);
    else passed++;
    pins[2][3] = ~pins[2][3];
    for (int c = 1; c <= SS + 1; c++) begin
      tick(30'h0, 1'b0, 4'h0, 32'h0);
      total++;
      if (edgeIrq !== (c == SS + 1)) $display("FAIL edge_irq cyc=%0d got=%b exp=%b", c, edgeIrq, c == SS + 1);
      else passed++;
    end
    tick(pendAddr(), 1'b1, 4'hF, 32'h4);
    total++;
    if (edgeIrq !== 1'b0) $display("FAIL edge_clr_irq got=%b exp=0", edgeIrq);
    else passed++;
    tick(pendAddr(), 1'b0, 4'h0, 32'h0);
    total++;
    if (memDataRead !== 32'h0) $display("FAIL edge_clr_rd got=%h exp=0", memDataRead);
    else passed++;
  endtask

  task automatic test_w1c_collision();
    pins[2][3] = ~pins[2][3];
    for (int c = 1; c <= SS; c++) tick(30'h0, 1'b0, 4'h0, 32'h0);
    tick(pendAddr(), 1'b1, 4'hF, 32'h4);
    total++;
    if (edgeIrq !== 1'b1) $display("FAIL w1c_irq got=%b exp=1", edgeIrq);
    else passed++;
    tick(pendAddr(), 1'b0, 4'h0, 32'h0);
    total++;
    if (memDataRead !== 32'h4) $display("FAIL w1c_rd got=%h exp=00000004", memDataRead);
    else passed++;
    tick(pendAddr(), 1'b1, 4'h1, 32'h4);
  endtask
`endif

  task automatic test_reset_mid_write();
    tick(dirAddr(1), 1'b0, 4'h0, 32'h0);
    doReset(dirAddr(1), 1'b1, 4'hF, 32'hFFFF_FFFF);
    total++;
    if (memDataRead !== 32'h0) $display("FAIL rst_mid_rd got=%h exp=0", memDataRead);
    else passed++;
    tick(dirAddr(1), 1'b0, 4'h0, 32'h0);
    total++;
    if (memDataRead !== 32'h0) $display("FAIL rst_mid_dir got=%h exp=0", memDataRead);
    else passed++;
    total++;
    if (portDirections[1] !== 32'h0) $display("FAIL rst_mid_reg got=%h exp=0", portDirections[1]);
    else passed++;
  endtask

  initial begin
    reset          = 1'b1;
    memAddress     = '0;
    memWriteEnable = 1'b0;
    memByteMask    = '0;
    memDataToWrite = '0;
    pins           = '0;
    resetModel();
    test_reset();
    test_byte_mask();
    test_input_latency();
    test_random();
`ifdef JZJPCC_MMIO_EDGE_EN
    test_edge();
    test_w1c_collision();
`endif
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
